// File: rtl/vga_sync_controller.sv
// vga_sync_controller
// Pixel timing master for the VGA text path: divides clk down to a pixel
// tick, runs the horizontal/vertical position counters and produces the
// registered sync pulses, the active-video flag and a frame-start strobe.
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit frame counter
// (frame_cnt) used for cursor/text blink timing.

module vga_sync_controller #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // The counters are 10 bits wide, so the totals must fit in 0..1023,
  // and the 4-bit divider only covers divide ratios of 1..16.
  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_sync_controller: H_TOTAL (%0d) exceeds 1024", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_sync_controller: V_TOTAL (%0d) exceeds 1024", V_TOTAL);
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_sync_controller: CLK_DIV (%0d) outside 1..16", CLK_DIV);
  end

  logic [3:0] div_cnt;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;

  // Pixel divider: free-running 0..CLK_DIV-1, restarted by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Pixel tick is suppressed during reset so CLK_DIV=1 does not tick early.
  always_comb begin
    p_tick     = (div_cnt == DIV_LAST) & ~reset;
    h_wrap     = (h_count == H_LAST);
    v_wrap     = (v_count == V_LAST);
    frame_wrap = p_tick & h_wrap & v_wrap;
  end

  // Position counters advance one pixel per tick; a line wrap bumps the row.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (p_tick) begin
      h_count <= h_wrap ? 10'd0 : h_count + 10'd1;
      if (h_wrap) begin
        v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
      end
    end
  end

  // Sync pulses and frame strobe are registered from the current position,
  // so they trail pixel_x/pixel_y by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~((h_count >= HS_START) && (h_count <= HS_END));
      vsync       <= ~((v_count >= VS_START) && (v_count <= VS_END));
      frame_start <= frame_wrap;
    end
  end

  // Active video is purely combinational so it lines up with pixel_x/pixel_y.
  always_comb begin
    pixel_x  = h_count;
    pixel_y  = v_count;
    video_on = (h_count < H_ACT) && (v_count < V_ACT);
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
